// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the multi-cycle RV32I-subset datapath: opcode, funct3
// and funct7 constants, ALU-op / state / immediate-format enums, and the
// instruction decoder used by multicycle_datapath.
// No ports (package).
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [1:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B
    } imm_fmt_e;

    typedef enum logic [2:0] {
        K_ILLEGAL, K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BRANCH
    } kind_e;

    typedef struct packed {
        kind_e    kind;
        alu_op_e  alu_op;
        imm_fmt_e imm_fmt;
        logic     uses_rs1;
        logic     uses_rs2;
        logic     uses_rd;
        logic     bne;
    } dec_t;

    // 32-bit sign-extended immediate; caller widens to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] ir, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default: return '0;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] ir, input logic bne_en);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3         = ir[14:12];
        f7         = ir[31:25];
        d.kind     = K_ILLEGAL;
        d.alu_op   = ALU_ADD;
        d.imm_fmt  = IMM_NONE;
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b0;
        d.uses_rd  = 1'b0;
        d.bne      = 1'b0;
        case (ir[6:0])
            OPC_OP: begin
                d.uses_rs2 = 1'b1;
                d.uses_rd  = 1'b1;
                if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
                    d.kind   = K_ALU_R;
                    d.alu_op = ALU_SUB;
                end else if (f7 == F7_BASE) begin
                    d.kind = K_ALU_R;
                    case (f3)
                        F3_ADD_SUB: d.alu_op = ALU_ADD;
                        F3_SLT:     d.alu_op = ALU_SLT;
                        F3_SLTU:    d.alu_op = ALU_SLTU;
                        F3_XOR:     d.alu_op = ALU_XOR;
                        F3_OR:      d.alu_op = ALU_OR;
                        F3_AND:     d.alu_op = ALU_AND;
                        default:    d.kind   = K_ILLEGAL;
                    endcase
                end
            end
            OPC_OPIMM: begin
                d.uses_rd = 1'b1;
                d.imm_fmt = IMM_I;
                d.kind    = K_ALU_I;
                case (f3)
                    F3_ADD_SUB: d.alu_op = ALU_ADD;
                    F3_SLT:     d.alu_op = ALU_SLT;
                    F3_OR:      d.alu_op = ALU_OR;
                    F3_AND:     d.alu_op = ALU_AND;
                    default:    d.kind   = K_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                d.uses_rd = 1'b1;
                d.imm_fmt = IMM_I;
                if (f3 == F3_LW) d.kind = K_LOAD;
            end
            OPC_STORE: begin
                d.uses_rs2 = 1'b1;
                d.imm_fmt  = IMM_S;
                if (f3 == F3_SW) d.kind = K_STORE;
            end
            OPC_BRANCH: begin
                d.uses_rs2 = 1'b1;
                d.imm_fmt  = IMM_B;
                d.alu_op   = ALU_SUB;
                if (f3 == F3_BEQ) begin
                    d.kind = K_BRANCH;
                end else if (f3 == F3_BNE && bne_en) begin
                    d.kind = K_BRANCH;
                    d.bne  = 1'b1;
                end
            end
            default: d.uses_rs1 = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_datapath_alu.sv
// -----------------------------------------------------------------------------
// alu
// Combinational ALU for the multi-cycle datapath.
// Ports: a, b (XLEN operands), op (alu_op_e), result (XLEN), zero (result==0).
// -----------------------------------------------------------------------------
module alu
    import datapath_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
// Multi-cycle RV32I-subset core (add/sub/and/or/xor/slt/sltu, addi/andi/ori/
// slti, lw, sw, beq) with req/ack instruction and data memory ports.
// Phases: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB]; HALT on any
// illegal condition (absorbing until reset).
// Optional: MULTICYCLE_DATAPATH_BNE_EN enables bne; otherwise bne halts.
// Ports:
//   clk, rst (async, active-low)
//   imem_req/imem_addr -> , imem_ack/imem_rdata <-        instruction fetch
//   dmem_req/dmem_we/dmem_addr/dmem_wdata -> ,
//   dmem_ack/dmem_rdata <-                                 data access
//   retire  one-cycle pulse per completed instruction
//   halted  sticky stop indication
// -----------------------------------------------------------------------------
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted
);

    localparam int unsigned AW = $clog2(NREGS);

`ifdef MULTICYCLE_DATAPATH_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] regs_q [NREGS];

    dec_t            dec;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rf_rs1, rf_rs2, imm, alu_b, alu_res, br_target, pc_plus4;
    logic            alu_zero, reg_bad, taken, rf_we;

    assign dec       = decode(ir_q, BNE_EN);
    assign rs1       = ir_q[19:15];
    assign rs2       = ir_q[24:20];
    assign rd        = ir_q[11:7];
    assign imm       = XLEN'($signed(imm32(ir_q, dec.imm_fmt)));
    // Entry 0 is never written, so x0 reads zero without a special case.
    assign rf_rs1    = regs_q[rs1[AW-1:0]];
    assign rf_rs2    = regs_q[rs2[AW-1:0]];
    assign reg_bad   = (dec.uses_rs1 && 32'(rs1) >= NREGS) ||
                       (dec.uses_rs2 && 32'(rs2) >= NREGS) ||
                       (dec.uses_rd  && 32'(rd)  >= NREGS);
    assign alu_b     = (dec.kind == K_ALU_R || dec.kind == K_BRANCH) ? b_q : imm;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign br_target = pc_q + imm;
    assign taken     = dec.bne ? ~alu_zero : alu_zero;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (a_q),
        .b      (alu_b),
        .op     (dec.alu_op),
        .result (alu_res),
        .zero   (alu_zero)
    );

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign halted     = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rf_we   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_rs1;
                b_d     = rf_rs2;
                state_d = (dec.kind == K_ILLEGAL || reg_bad) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (dec.kind)
                    K_ALU_R, K_ALU_I: begin
                        res_d   = alu_res;
                        state_d = S_WB;
                    end
                    K_LOAD, K_STORE: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_d = S_HALT;
                        end else begin
                            addr_d  = alu_res;
                            wdata_d = b_q;
                            we_d    = (dec.kind == K_STORE);
                            state_d = S_MEM;
                        end
                    end
                    K_BRANCH: begin
                        if (taken && br_target[1]) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d    = taken ? br_target : pc_plus4;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (we_q) begin
                        pc_d    = pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = pc_plus4;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            regs_q[rd[AW-1:0]] <= res_q;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

    localparam int EV_F = 0;
    localparam int EV_L = 1;
    localparam int EV_S = 2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        retire, halted;

    logic [31:0] imem [0:63];
    int unsigned idelay, ddelay;
    logic [31:0] dm_rdata;

    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    int   retire_log[$];
    int   exp_ret[$];
    int   cyc, dreq_cycles, halt_cyc;

    always #5 clk = ~clk;

    multicycle_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responders: ack after idelay/ddelay wait cycles, one-cycle ack.
    initial begin
        int unsigned iw, dw;
        iw = 0; dw = 0;
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (imem_req && !imem_ack && iw >= idelay) begin
                imem_ack = 1'b1; imem_rdata = imem[imem_addr[7:2]]; iw = 0;
            end else begin
                if (imem_req && !imem_ack) iw++; else iw = 0;
                imem_ack = 1'b0;
            end
            if (dmem_req && !dmem_ack && dw >= ddelay) begin
                dmem_ack = 1'b1; dmem_rdata = dm_rdata; dw = 0;
            end else begin
                if (dmem_req && !dmem_ack) dw++; else dw = 0;
                dmem_ack = 1'b0;
            end
        end
    end

    task automatic match_event(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got kind %0d addr %h, expected no event", k, a);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_addr", a, e.addr);
            if (k == EV_S) check("store_data", d, e.data);
        end
    endtask

    // Monitor: cycle 1 is the first FETCH cycle after reset release.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                if (imem_req && imem_ack) match_event(EV_F, imem_addr, '0);
                if (dmem_req && dmem_ack) match_event(dmem_we ? EV_S : EV_L, dmem_addr, dmem_wdata);
                if (dmem_req) dreq_cycles++;
                if (retire) retire_log.push_back(cyc);
                if (halted && halt_cyc == 0) halt_cyc = cyc;
            end
        end
    end

    task automatic push_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = 2'(k); e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic prep_test();
        rst_n = 1'b0;
        exp_q.delete(); retire_log.delete(); exp_ret.delete();
        cyc = 0; dreq_cycles = 0; halt_cyc = 0;
        idelay = 0; ddelay = 0; dm_rdata = '0;
        for (int i = 0; i < 64; i++) imem[i] = '0;
    endtask

    task automatic release_rst();
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic finish_test(input string tag);
        check($sformatf("%s_events_left", tag), 32'(exp_q.size()), 32'd0);
        check($sformatf("%s_retire_count", tag), 32'(retire_log.size()), 32'(exp_ret.size()));
        for (int i = 0; i < exp_ret.size() && i < retire_log.size(); i++)
            check($sformatf("%s_retire_cycle%0d", tag, i), 32'(retire_log[i]), 32'(exp_ret[i]));
    endtask

    task automatic check_reset(input string tag);
        check($sformatf("%s_imem_req", tag),   32'(imem_req),   32'd0);
        check($sformatf("%s_imem_addr", tag),  imem_addr,       32'h0);
        check($sformatf("%s_dmem_req", tag),   32'(dmem_req),   32'd0);
        check($sformatf("%s_dmem_we", tag),    32'(dmem_we),    32'd0);
        check($sformatf("%s_dmem_addr", tag),  dmem_addr,       32'h0);
        check($sformatf("%s_dmem_wdata", tag), dmem_wdata,      32'h0);
        check($sformatf("%s_retire", tag),     32'(retire),     32'd0);
        check($sformatf("%s_halted", tag),     32'(halted),     32'd0);
    endtask

    initial begin
        idelay = 0; ddelay = 0; dm_rdata = '0;
        #1 rst_n = 1'b0;
        #1 check_reset("init");

        // addi x1,x0,5; addi x2,x1,-7; sw x1,0(x0); sw x2,4(x0); illegal
        prep_test();
        imem[0] = 32'h00500093; imem[1] = 32'hFF908113;
        imem[2] = 32'h00102023; imem[3] = 32'h00202223;
        push_ev(EV_F, 32'h0, '0); push_ev(EV_F, 32'h4, '0); push_ev(EV_F, 32'h8, '0);
        push_ev(EV_S, 32'h0, 32'h5); push_ev(EV_F, 32'hC, '0);
        push_ev(EV_S, 32'h4, 32'hFFFF_FFFE); push_ev(EV_F, 32'h10, '0);
        exp_ret = '{4, 8, 12, 16};
        release_rst();
        repeat (30) @(posedge clk);
        finish_test("addi");
        check("addi_dreq_cycles", 32'(dreq_cycles), 32'd2);
        check("addi_halt_cycle", 32'(halt_cyc), 32'd19);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check_reset("async");

        // lw x3,4(x0) with 3 wait cycles; sw x3,8(x0); illegal
        prep_test();
        ddelay = 3; dm_rdata = 32'hDEAD_BEEF;
        imem[0] = 32'h00402183; imem[1] = 32'h00302423;
        push_ev(EV_F, 32'h0, '0); push_ev(EV_L, 32'h4, '0); push_ev(EV_F, 32'h4, '0);
        push_ev(EV_S, 32'h8, 32'hDEAD_BEEF); push_ev(EV_F, 32'h8, '0);
        exp_ret = '{8, 15};
        release_rst();
        repeat (30) @(posedge clk);
        finish_test("lw");
        check("lw_dreq_cycles", 32'(dreq_cycles), 32'd8);

        // addi x1,x0,1; beq +12; (0x10) beq -8; (0x08) beq x0,x1 not taken; (0x0C) bne x0,x1,8
        prep_test();
        imem[0] = 32'h00100093; imem[1] = 32'h00000663; imem[2] = 32'h04100063;
        imem[3] = 32'h00101463; imem[4] = 32'hFE000CE3;
        push_ev(EV_F, 32'h0, '0); push_ev(EV_F, 32'h4, '0); push_ev(EV_F, 32'h10, '0);
        push_ev(EV_F, 32'h8, '0); push_ev(EV_F, 32'hC, '0);
`ifdef MULTICYCLE_DATAPATH_BNE_EN
        push_ev(EV_F, 32'h14, '0);
        exp_ret = '{4, 7, 10, 13, 16};
`else
        exp_ret = '{4, 7, 10, 13};
`endif
        release_rst();
        repeat (30) @(posedge clk);
        finish_test("branch");
        check("branch_dreq_cycles", 32'(dreq_cycles), 32'd0);
`ifdef MULTICYCLE_DATAPATH_BNE_EN
        check("branch_halt_cycle", 32'(halt_cyc), 32'd19);
`else
        check("branch_halt_cycle", 32'(halt_cyc), 32'd16);
`endif

        // sw x1,2(x0): misaligned
        prep_test();
        imem[0] = 32'h00102123;
        push_ev(EV_F, 32'h0, '0);
        release_rst();
        repeat (15) @(posedge clk);
        finish_test("misalign");
        check("misalign_dreq_cycles", 32'(dreq_cycles), 32'd0);
        check("misalign_halt_cycle", 32'(halt_cyc), 32'd4);
        #1 check("misalign_imem_req", 32'(imem_req), 32'd0);

        // beq x0,x0,+6: taken target with bit1 set
        prep_test();
        imem[0] = 32'h00000363;
        push_ev(EV_F, 32'h0, '0);
        release_rst();
        repeat (15) @(posedge clk);
        finish_test("brtarget");
        check("brtarget_halt_cycle", 32'(halt_cyc), 32'd4);

        // addi x20,x0,1 with NREGS=16
        prep_test();
        imem[0] = 32'h00100A13;
        push_ev(EV_F, 32'h0, '0);
        release_rst();
        repeat (15) @(posedge clk);
        finish_test("regidx");
        check("regidx_halt_cycle", 32'(halt_cyc), 32'd3);

        // Reset while a fetch at 0x08 is stalled
        prep_test();
        imem[0] = 32'h00000013; imem[1] = 32'h00000013; imem[2] = 32'h00000013;
        push_ev(EV_F, 32'h0, '0); push_ev(EV_F, 32'h4, '0);
        release_rst();
        for (int i = 0; i < 20 && retire_log.size() < 2; i++) @(posedge clk);
        idelay = 100;
        repeat (3) @(negedge clk);
        #2 check("stall_imem_req", 32'(imem_req), 32'd1);
        check("stall_imem_addr", imem_addr, 32'h8);
        rst_n = 1'b0;
        #1 check("rstmid_imem_req", 32'(imem_req), 32'd0);
        check("rstmid_imem_addr", imem_addr, 32'h0);
        check("rstmid_events_left", 32'(exp_q.size()), 32'd0);
        prep_test();
        push_ev(EV_F, 32'h0, '0);
        release_rst();
        repeat (10) @(posedge clk);
        finish_test("restart");
        check("restart_halt_cycle", 32'(halt_cyc), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
